// File: rtl/decode_issue_if.sv
// rtl/decode_issue_if.sv - fetch handshake and EX operand/result bundle between fetch/ALU and decode_issue
interface decode_issue_if;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;
    logic [4:0]  op_dec;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        ex_valid;
    logic [7:0]  ans_tmp;
    logic [3:0]  flag_ex;

    modport master (
        output inst_valid, inst, ans_tmp, flag_ex,
        input  inst_ready, op_dec, A, B, ex_valid
    );

    modport slave (
        input  inst_valid, inst, ans_tmp, flag_ex,
        output inst_ready, op_dec, A, B, ex_valid
    );
endinterface

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage: register file, operand bypass, flags, branch resolution
module decode_issue #(
    parameter logic [7:0] REG_RST = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    decode_issue_if.slave      bus,
    input  logic               ld_we,
    input  logic [2:0]         ld_addr,
    input  logic [7:0]         ld_data,
    output logic [3:0]         flags,
    output logic               branch_taken,
    output logic [7:0]         branch_target,
    output logic               halted
);

    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b10001;

    typedef enum logic [1:0] {S_RUN, S_STALL, S_BRANCH, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  rf_q [8];
    logic [4:0]  op_q, op_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic        exv_q, exv_d;
    logic        exwe_q, exwe_d;
    logic [2:0]  rd_q, rd_d;
    logic [3:0]  flags_q;
    logic [4:0]  br_op_q, br_op_d;
    logic [7:0]  tgt_q, tgt_d;

    logic [4:0]  in_op;
    logic [2:0]  in_rd, in_rs;
    logic [7:0]  in_imm;
    logic [7:0]  opa, rs_val, opb;
    logic        ex_flag_op, hazard, accept;

    function automatic logic writes_rd(input logic [4:0] op);
        case (op) inside
            5'b00000, 5'b00001, 5'b00010, [5'b00100:5'b00111],
            5'b01000, 5'b01001, 5'b01010, [5'b01100:5'b01111],
            5'b10110, [5'b11001:5'b11011]: writes_rd = 1'b1;
            default:                       writes_rd = 1'b0;
        endcase
    endfunction

    assign in_op  = bus.inst[15:11];
    assign in_rd  = bus.inst[10:8];
    assign in_rs  = bus.inst[7:5];
    assign in_imm = bus.inst[7:0];

    // Conditional branches must see the flags of the op currently in EX.
    assign ex_flag_op = exv_q && (op_q[4:2] != 3'b111) && (op_q != OP_NOP);
    assign hazard     = (in_op[4:2] == 3'b111) && ex_flag_op;
    assign accept     = bus.inst_valid && bus.inst_ready;

    // Bypass priority: EX result over load data over the register file.
    always_comb begin
        opa = rf_q[in_rd];
        if (ld_we && ld_addr == in_rd) opa = ld_data;
        if (exv_q && exwe_q && rd_q == in_rd) opa = bus.ans_tmp;
        rs_val = rf_q[in_rs];
        if (ld_we && ld_addr == in_rs) rs_val = ld_data;
        if (exv_q && exwe_q && rd_q == in_rs) rs_val = bus.ans_tmp;
        opb = (in_op[4:3] == 2'b01) ? in_imm : rs_val;
    end

    always_comb begin
        state_d        = state_q;
        op_d           = OP_NOP;
        a_d            = 8'h00;
        b_d            = 8'h00;
        exv_d          = 1'b0;
        exwe_d         = 1'b0;
        rd_d           = 3'd0;
        br_op_d        = br_op_q;
        tgt_d          = tgt_q;
        bus.inst_ready = 1'b0;
        branch_taken   = 1'b0;
        case (state_q)
            S_RUN, S_STALL: begin
                bus.inst_ready = !hazard;
                if (accept) begin
                    if (in_op == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        op_d   = in_op;
                        a_d    = opa;
                        b_d    = opb;
                        exv_d  = 1'b1;
                        exwe_d = writes_rd(in_op);
                        rd_d   = in_rd;
                        if (in_op == OP_JMP || in_op[4:2] == 3'b111) begin
                            state_d = S_BRANCH;
                            br_op_d = in_op;
                            tgt_d   = in_imm;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end else if (state_q == S_RUN && bus.inst_valid && hazard) begin
                    state_d = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_BRANCH: begin
                branch_taken = (br_op_q == OP_JMP) || flags_q[br_op_q[1:0]];
                state_d      = S_RUN;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= REG_RST;
            state_q <= S_RUN;
            op_q    <= OP_NOP;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            exv_q   <= 1'b0;
            exwe_q  <= 1'b0;
            rd_q    <= 3'd0;
            flags_q <= 4'h0;
            br_op_q <= OP_NOP;
            tgt_q   <= 8'h00;
        end else begin
            if (ld_we) rf_q[ld_addr] <= ld_data;
            // Issued later so the EX write wins on a same-register collision.
            if (exv_q && exwe_q) rf_q[rd_q] <= bus.ans_tmp;
            if (ex_flag_op) flags_q <= bus.flag_ex;
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exv_q   <= exv_d;
            exwe_q  <= exwe_d;
            rd_q    <= rd_d;
            br_op_q <= br_op_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.op_dec    = op_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.ex_valid  = exv_q;
    assign flags         = flags_q;
    assign branch_target = tgt_q;
    assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed bench for decode_issue with a behavioural reference model
module tb_decode_issue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_we = 1'b0;
    logic [2:0] ld_addr = 3'd0;
    logic [7:0] ld_data = 8'h00;
    logic [3:0] flags;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halted;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    logic [7:0] last_tgt = 8'h00;

    always #5 clk = ~clk;

    decode_issue_if bus();

    decode_issue #(.REG_RST(8'h00)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .flags(flags), .branch_taken(branch_taken),
        .branch_target(branch_target), .halted(halted)
    );

    // Toy ALU: add for op[2:0]=000, subtract for 010, otherwise pass B. Result {P,V,Z,C,res}.
    function automatic logic [11:0] alu(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        case (op[2:0])
            3'b000:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'b010:  begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            default: begin r = b; c = 1'b0; v = 1'b0; end
        endcase
        return {^r, v, (r == 8'h00), c, r};
    endfunction

    always_comb begin
        {bus.flag_ex, bus.ans_tmp} = alu(bus.op_dec, bus.A, bus.B);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: architectural state plus the word currently in EX.
    logic [7:0] m_rf [8];
    logic [3:0] m_flags;
    int         m_mode;              // 0 run, 1 stall, 2 branch, 3 halt
    logic       m_exv;
    logic [4:0] m_op;
    logic [7:0] m_a, m_b, m_tgt;
    logic [2:0] m_rd;
    logic [4:0] m_br;
    bit         m_live = 1'b0;

    function automatic bit is_writer(input logic [4:0] op);
        return op inside {5'b00000, 5'b00001, 5'b00010, [5'b00100:5'b00111],
                          5'b01000, 5'b01001, 5'b01010, [5'b01100:5'b01111],
                          5'b10110, [5'b11001:5'b11011]};
    endfunction

    function automatic bit flag_op(input logic [4:0] op);
        return (op[4:2] != 3'b111) && (op != 5'b11000);
    endfunction

    function automatic bit m_ready();
        return (m_mode <= 1) && !((bus.inst[15:13] == 3'b111) && m_exv && flag_op(m_op));
    endfunction

    function automatic bit m_taken();
        return (m_mode == 2) && ((m_br == 5'b10000) || m_flags[m_br[1:0]]);
    endfunction

    always @(posedge clk) begin
        logic [11:0] res;
        logic [4:0]  op;
        bit          acc, haz;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
            m_flags = 4'h0; m_mode = 0; m_exv = 1'b0; m_op = 5'b11000;
            m_a = 8'h00; m_b = 8'h00; m_rd = 3'd0; m_br = 5'b11000; m_tgt = 8'h00;
            m_live = 1'b1;
        end else if (m_live) begin
            acc = bus.inst_valid && m_ready();
            haz = bus.inst_valid && !m_ready() && (m_mode == 0);
            res = alu(m_op, m_a, m_b);
            if (ld_we) m_rf[ld_addr] = ld_data;
            if (m_exv && is_writer(m_op)) m_rf[m_rd] = res[7:0];
            if (m_exv && flag_op(m_op)) m_flags = res[11:8];
            // Operands read after this edge's writes equal the bypassed values.
            if (acc) begin
                op = bus.inst[15:11];
                if (op == 5'b10001) begin
                    m_mode = 3; m_exv = 1'b0; m_op = 5'b11000;
                end else begin
                    m_exv = 1'b1; m_op = op; m_rd = bus.inst[10:8];
                    m_a = m_rf[bus.inst[10:8]];
                    m_b = (op[4:3] == 2'b01) ? bus.inst[7:0] : m_rf[bus.inst[7:5]];
                    if (op == 5'b10000 || op[4:2] == 3'b111) begin
                        m_mode = 2; m_br = op; m_tgt = bus.inst[7:0];
                    end else begin
                        m_mode = 0;
                    end
                end
            end else begin
                m_exv = 1'b0; m_op = 5'b11000;
                if (m_mode != 3) m_mode = haz ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("inst_ready", 16'(bus.inst_ready), 16'(m_ready()));
            chk("ex_valid", 16'(bus.ex_valid), 16'(m_exv));
            chk("op_dec", 16'(bus.op_dec), 16'(m_op));
            chk("flags", 16'(flags), 16'(m_flags));
            chk("halted", 16'(halted), 16'(m_mode == 3));
            chk("branch_taken", 16'(branch_taken), 16'(m_taken()));
            if (m_exv) begin
                chk("A", 16'(bus.A), 16'(m_a));
                chk("B", 16'(bus.B), 16'(m_b));
            end
            if (m_taken()) chk("branch_target", 16'(branch_target), 16'(m_tgt));
        end
        if (branch_taken) begin
            pulses++;
            last_tgt = branch_target;
        end
    end

    task automatic send(input logic [15:0] w, output int waits);
        bit r;
        waits = 0;
        bus.inst_valid = 1'b1;
        bus.inst = w;
        forever begin
            @(negedge clk);
            r = bus.inst_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waits++;
            if (waits > 20) begin
                chk("send_timeout", 16'(waits), 16'd0);
                break;
            end
        end
        bus.inst_valid = 1'b0;
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int p0;
        bus.inst_valid = 1'b0;
        bus.inst = 16'h0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 16'(bus.inst_ready), 16'd1);
        chk("rst_exv", 16'(bus.ex_valid), 16'd0);
        chk("rst_op", 16'(bus.op_dec), 16'h0018);
        chk("rst_flags", 16'(flags), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        realign();

        // ADI R1,5 then ADD R2,R1 back-to-back
        send(16'h4105, w);
        send(16'h0220, w);
        chk("t1_no_stall", 16'(w), 16'd0);
        @(negedge clk);
        chk("t1_bypass_B", 16'(bus.B), 16'h0005);
        chk("t1_A", 16'(bus.A), 16'h0000);
        realign();
        realign();

        // Unused opcode 00011 on R2: reads 5, updates flags, writes nothing
        send(16'h1A00, w);
        @(negedge clk);
        chk("t1_wb_R2", 16'(bus.A), 16'h0005);
        chk("unused_exv", 16'(bus.ex_valid), 16'd1);
        realign();
        @(negedge clk);
        chk("unused_flags", 16'(flags), 16'h0002);
        realign();
        send(16'h1A00, w);
        @(negedge clk);
        chk("unused_no_write", 16'(bus.A), 16'h0005);
        realign();

        // JZ not taken: ADI R6,1 clears Z, idle cycle removes the hazard
        send(16'h4601, w);
        realign();
        p0 = pulses;
        send(16'hE940, w);
        chk("t3_no_stall", 16'(w), 16'd0);
        send(16'h1E00, w);
        chk("t3_branch_bubble", 16'(w), 16'd1);
        chk("t3_not_taken", 16'(pulses), 16'(p0));
        @(negedge clk);
        chk("t3_R6", 16'(bus.A), 16'h0001);
        realign();

        // SBI R3,0 then JZ 0x40: one stall, then a taken branch
        send(16'h5300, w);
        p0 = pulses;
        send(16'hE940, w);
        chk("t2_one_stall", 16'(w), 16'd1);
        chk("t2_flags", 16'(flags), 16'h0002);
        send(16'h1B00, w);
        chk("t2_branch_bubble", 16'(w), 16'd1);
        chk("t2_taken_once", 16'(pulses), 16'(p0 + 1));
        chk("t2_target", 16'(last_tgt), 16'h0040);
        @(negedge clk);
        chk("t2_R3", 16'(bus.A), 16'h0000);
        realign();

        // Same-register collision: EX writes R4=0x11 while load writes R4=0xAA
        send(16'h4411, w);
        ld_we = 1'b1; ld_addr = 3'd4; ld_data = 8'hAA;
        realign();
        ld_we = 1'b0;
        send(16'h1C00, w);
        @(negedge clk);
        chk("t4_ex_wins", 16'(bus.A), 16'h0011);
        realign();

        // Different registers: EX writes R5=0x22, load writes R6=0x77
        send(16'h4522, w);
        ld_we = 1'b1; ld_addr = 3'd6; ld_data = 8'h77;
        realign();
        ld_we = 1'b0;
        send(16'h1D00, w);
        @(negedge clk);
        chk("t4_R5", 16'(bus.A), 16'h0022);
        realign();
        send(16'h1E00, w);
        @(negedge clk);
        chk("t4_R6", 16'(bus.A), 16'h0077);
        realign();

        // HALT, then valid words are refused until reset
        send(16'h8800, w);
        bus.inst_valid = 1'b1;
        bus.inst = 16'h4105;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_halt_ready", 16'(bus.inst_ready), 16'd0);
            chk("t5_halted", 16'(halted), 16'd1);
        end
        realign();
        rst = 1'b1;
        realign();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after_rst", 16'(bus.inst_ready), 16'd1);
        chk("t5_halted_clear", 16'(halted), 16'd0);
        realign();
        bus.inst_valid = 1'b0;
        @(negedge clk);
        chk("t5_exv", 16'(bus.ex_valid), 16'd1);
        chk("t5_R1_reset", 16'(bus.A), 16'h0000);
        realign();
        repeat (3) realign();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
